// File: rtl/mpu_pkg.sv
// Shared constants for the MPU6050 burst assembler: frame layout, sample width,
// default timing/calibration parameters and FSM state encoding.
package mpu_pkg;

    localparam int FRAME_BYTES     = 14;
    localparam int SAMPLE_W        = 16;
    localparam int NUM_SAMPLES     = FRAME_BYTES / 2;
    localparam int GAP_TIMEOUT_DEF = 4096;
    localparam int CAL_SHIFT_DEF   = 6;

    localparam logic [7:0] MPU_ACCEL_XOUT_H = 8'h3B;

    // Byte offsets inside the burst starting at MPU_ACCEL_XOUT_H; big-endian pairs.
    localparam logic [3:0] AX_H = 4'd0,  AX_L = 4'd1;
    localparam logic [3:0] AY_H = 4'd2,  AY_L = 4'd3;
    localparam logic [3:0] AZ_H = 4'd4,  AZ_L = 4'd5;
    localparam logic [3:0] T_H  = 4'd6,  T_L  = 4'd7;
    localparam logic [3:0] GX_H = 4'd8,  GX_L = 4'd9;
    localparam logic [3:0] GY_H = 4'd10, GY_L = 4'd11;
    localparam logic [3:0] GZ_H = 4'd12, GZ_L = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } mpu_state_e;

endpackage

// File: rtl/mpu_gyro_bias.sv
// Gyro bias calibration: sums the first 2^CAL_SHIFT frames per axis, then subtracts
// the averaged bias from every later sample with saturation to 16 bits.
module mpu_gyro_bias
    import mpu_pkg::*;
#(
    parameter int CAL_SHIFT = CAL_SHIFT_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     frame_i,
    input  logic [2:0][SAMPLE_W-1:0] gyro_raw_i,
    output logic [2:0][SAMPLE_W-1:0] gyro_corr_o,
    output logic                     cal_done_o
);

    localparam int ACC_W = SAMPLE_W + CAL_SHIFT;

    logic [2:0][ACC_W-1:0]    acc_q, acc_d;
    logic [2:0][SAMPLE_W-1:0] bias_q;
    logic [CAL_SHIFT-1:0]     cnt_q;
    logic                     cal_done_q;
    logic [SAMPLE_W:0]        diff;

    always_comb begin
        acc_d       = acc_q;
        gyro_corr_o = '0;
        diff        = '0;
        for (int a = 0; a < 3; a++) begin
            acc_d[a] = acc_q[a] + {{CAL_SHIFT{gyro_raw_i[a][SAMPLE_W-1]}}, gyro_raw_i[a]};
            // 17-bit difference; the top two bits disagree exactly when it overflows 16 bits
            diff = {gyro_raw_i[a][SAMPLE_W-1], gyro_raw_i[a]} - {bias_q[a][SAMPLE_W-1], bias_q[a]};
            case (diff[SAMPLE_W -: 2])
                2'b01:   gyro_corr_o[a] = {1'b0, {(SAMPLE_W-1){1'b1}}};
                2'b10:   gyro_corr_o[a] = {1'b1, {(SAMPLE_W-1){1'b0}}};
                default: gyro_corr_o[a] = diff[SAMPLE_W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            bias_q     <= '0;
            cnt_q      <= '0;
            cal_done_q <= 1'b0;
        end else if (frame_i && !cal_done_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) begin
                cal_done_q <= 1'b1;
                // Upper slice of the sum is the arithmetic shift right by CAL_SHIFT
                for (int a = 0; a < 3; a++) bias_q[a] <= acc_d[a][ACC_W-1:CAL_SHIFT];
            end
        end
    end

    assign cal_done_o = cal_done_q;

endmodule

// File: rtl/mpu_frame_assembler.sv
// Reassembles the MPU6050 14-byte accel/temp/gyro burst into seven samples on a valid/ready port.
// Define MPU_GYRO_BIAS_CAL_EN to enable gyro bias calibration over the first frames after reset.
module mpu_frame_assembler
    import mpu_pkg::*;
#(
    parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
`ifdef MPU_GYRO_BIAS_CAL_EN
   ,parameter int CAL_SHIFT   = CAL_SHIFT_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        rd_busy,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [15:0] temp_raw,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        cal_done
);

    localparam int TMO_W = $clog2(GAP_TIMEOUT + 1);
    localparam int IDX_W = $clog2(FRAME_BYTES);

    mpu_state_e                              state_q;
    logic [IDX_W-1:0]                        idx_q;
    logic [TMO_W-1:0]                        tmo_q;
    logic [7:0]                              shadow_q [FRAME_BYTES-1];
    logic                                    rd_busy_q;
    logic                                    out_valid_q, frame_err_q, overrun_q;
    logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0]    smp_q, raw_d, pub_d;
    logic [2:0][SAMPLE_W-1:0]                gyro_d;
    logic                                    cal_done_w, frame_done, rd_fall, timeout;

    assign rd_fall    = rd_busy_q & ~rd_busy;
    assign timeout    = (tmo_q == TMO_W'(GAP_TIMEOUT - 1));
    assign frame_done = (state_q == ST_COLLECT) && byte_valid && (idx_q == GZ_L);

    // The last low byte is taken straight from byte_in so the frame lands on the
    // outputs at the same edge that captures it, making them visible in PUBLISH.
    always_comb begin
        raw_d = '0;
        for (int s = 0; s < NUM_SAMPLES - 1; s++)
            raw_d[s] = {shadow_q[2*s], shadow_q[2*s+1]};
        raw_d[NUM_SAMPLES-1] = {shadow_q[GZ_H], byte_in};
        pub_d = {gyro_d, raw_d[3:0]};
    end

`ifdef MPU_GYRO_BIAS_CAL_EN
    mpu_gyro_bias #(
        .CAL_SHIFT (CAL_SHIFT)
    ) u_bias (
        .clk_i       (clk),
        .rst_i       (rst),
        .frame_i     (frame_done),
        .gyro_raw_i  (raw_d[6:4]),
        .gyro_corr_o (gyro_d),
        .cal_done_o  (cal_done_w)
    );
`else
    assign gyro_d     = raw_d[6:4];
    assign cal_done_w = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            rd_busy_q   <= 1'b0;
            smp_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < FRAME_BYTES - 1; i++) shadow_q[i] <= '0;
        end else begin
            rd_busy_q   <= rd_busy;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (byte_valid) begin
                        tmo_q <= '0;
                        if (idx_q == GZ_L) begin
                            idx_q   <= '0;
                            state_q <= ST_PUBLISH;
                        end else begin
                            shadow_q[idx_q] <= byte_in;
                            idx_q           <= idx_q + 1'b1;
                        end
                    end else if (timeout || rd_fall) begin
                        frame_err_q <= 1'b1;
                        idx_q       <= '0;
                        tmo_q       <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and PUBLISH both take a strobe as byte 0 of a new frame
                    if (byte_valid) begin
                        shadow_q[AX_H] <= byte_in;
                        idx_q          <= AX_L;
                        tmo_q          <= '0;
                        state_q        <= ST_COLLECT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase

            if (frame_done && cal_done_w) begin
                smp_q       <= pub_d;
                out_valid_q <= 1'b1;
                if (out_valid_q && !out_ready) overrun_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign accel_x   = smp_q[0];
    assign accel_y   = smp_q[1];
    assign accel_z   = smp_q[2];
    assign temp_raw  = smp_q[3];
    assign gyro_x    = smp_q[4];
    assign gyro_y    = smp_q[5];
    assign gyro_z    = smp_q[6];
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign cal_done  = cal_done_w;

endmodule

// File: tb/tb_mpu_frame_assembler.sv
// Bench for mpu_frame_assembler: directed scenarios plus random frames, every cycle compared
// against a frame-level reference model of publish, handshake, overrun and bias behaviour.
module tb_mpu_frame_assembler;

    localparam int GAP_TIMEOUT = 4096;
    localparam int CAL_SHIFT   = 2;
    localparam int CAL_N       = 1 << CAL_SHIFT;

    logic        clk = 1'b0;
    logic        rst, byte_valid, rd_busy, out_ready;
    logic [7:0]  byte_in;
    logic [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z;
    logic        out_valid, frame_err, overrun, cal_done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] cur [14];
    int         m_smp [7];
    int         m_sum [3];
    int         m_bias [3];
    int         m_cal_cnt;
    logic       m_valid, m_overrun, m_cal_done;
    logic       last_next, err_next;

    mpu_frame_assembler #(
`ifdef MPU_GYRO_BIAS_CAL_EN
        .CAL_SHIFT   (CAL_SHIFT),
`endif
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .rd_busy    (rd_busy),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .accel_z    (accel_z),
        .temp_raw   (temp_raw),
        .gyro_x     (gyro_x),
        .gyro_y     (gyro_y),
        .gyro_z     (gyro_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .cal_done   (cal_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int floordiv(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_frame(input logic rdy);
        int raw [7];
        logic signed [15:0] s16;
        for (int i = 0; i < 7; i++) begin
            s16    = {cur[2*i], cur[2*i+1]};
            raw[i] = int'(s16);
        end
        if (!m_cal_done) begin
            for (int a = 0; a < 3; a++) m_sum[a] += raw[4+a];
            m_cal_cnt++;
            if (m_cal_cnt == CAL_N) begin
                for (int a = 0; a < 3; a++) m_bias[a] = floordiv(m_sum[a], CAL_N);
                m_cal_done = 1'b1;
            end
        end else begin
            if (m_valid && !rdy) m_overrun = 1'b1;
            m_valid = 1'b1;
            for (int i = 0; i < 4; i++) m_smp[i] = raw[i];
            for (int a = 0; a < 3; a++) m_smp[4+a] = clamp16(raw[4+a] - m_bias[a]);
        end
    endtask

    // One clock: advance the model by the inputs present at the edge, then compare everything.
    task automatic tick();
        logic rdy_s, done_s, err_s;
        rdy_s  = out_ready;
        done_s = last_next;
        err_s  = err_next;
        @(posedge clk);
        #1;
        last_next = 1'b0;
        err_next  = 1'b0;
        if (done_s) model_frame(rdy_s);
        else if (m_valid && rdy_s) m_valid = 1'b0;
        chk("out_valid", 16'(out_valid), 16'(m_valid));
        chk("overrun",   16'(overrun),   16'(m_overrun));
        chk("frame_err", 16'(frame_err), 16'(err_s));
        chk("cal_done",  16'(cal_done),  16'(m_cal_done));
        chk("accel_x",  accel_x,  16'(m_smp[0]));
        chk("accel_y",  accel_y,  16'(m_smp[1]));
        chk("accel_z",  accel_z,  16'(m_smp[2]));
        chk("temp_raw", temp_raw, 16'(m_smp[3]));
        chk("gyro_x",   gyro_x,   16'(m_smp[4]));
        chk("gyro_y",   gyro_y,   16'(m_smp[5]));
        chk("gyro_z",   gyro_z,   16'(m_smp[6]));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        byte_in    = b;
        byte_valid = 1'b1;
        last_next  = last;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 14; i++) send_byte(cur[i], i == 13);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 14; i++) cur[i] = 8'($urandom);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int fe_at;
        rst = 1'b1; byte_in = '0; byte_valid = 1'b0; rd_busy = 1'b0; out_ready = 1'b0;
        last_next = 1'b0; err_next = 1'b0;
        m_valid = 1'b0; m_overrun = 1'b0; m_cal_cnt = 0;
        for (int i = 0; i < 7; i++) m_smp[i] = 0;
        for (int a = 0; a < 3; a++) begin m_sum[a] = 0; m_bias[a] = 0; end
`ifdef MPU_GYRO_BIAS_CAL_EN
        m_cal_done = 1'b0;
`else
        m_cal_done = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_frame_err", 16'(frame_err), 16'h0);
        chk("rst_overrun",   16'(overrun),   16'h0);
        chk("rst_accel_x",   accel_x, 16'h0);
        chk("rst_gyro_z",    gyro_z,  16'h0);
        chk("rst_cal_done",  16'(cal_done), 16'(m_cal_done));

`ifdef MPU_GYRO_BIAS_CAL_EN
        for (int f = 0; f < CAL_N; f++) begin
            rand_frame(); cur[8] = 8'h00; cur[9] = 8'd100;
            send_frame();
            repeat (2) tick();
        end
        chk("cal_done_rise", 16'(cal_done), 16'h1);
        rand_frame(); cur[8] = 8'h00; cur[9] = 8'd90;
        send_frame();
        chk("gyro_x_minus_bias", gyro_x, 16'hFFF6);
        accept();
        rand_frame(); cur[8] = 8'h80; cur[9] = 8'h00;
        send_frame();
        chk("gyro_x_saturated", gyro_x, 16'h8000);
        accept();
`endif

        // Counting pattern; output must appear exactly one cycle after the 14th strobe
        for (int i = 0; i < 14; i++) cur[i] = 8'(i + 1);
        for (int i = 0; i < 13; i++) send_byte(cur[i], 1'b0);
        chk("pre_publish_valid", 16'(out_valid), 16'h0);
        send_byte(cur[13], 1'b1);
        chk("count_valid",   16'(out_valid), 16'h1);
        chk("count_accel_x", accel_x, 16'h0102);
`ifndef MPU_GYRO_BIAS_CAL_EN
        chk("count_gyro_z",  gyro_z,  16'h0D0E);
`endif
        tick();
        accept();

        // Most negative accel value, held while the consumer stalls
        rand_frame(); cur[0] = 8'h80; cur[1] = 8'h00;
        send_frame();
        repeat (6) tick();
        chk("hold_accel_x", accel_x, 16'h8000);
        chk("hold_valid",   16'(out_valid), 16'h1);
        accept();

        // Acceptance on the same edge as the next publish is not an overrun
        rand_frame(); send_frame();
        rand_frame();
        for (int i = 0; i < 13; i++) send_byte(cur[i], 1'b0);
        out_ready = 1'b1;
        send_byte(cur[13], 1'b1);
        out_ready = 1'b0;
        chk("same_cycle_overrun", 16'(overrun),   16'h0);
        chk("same_cycle_valid",   16'(out_valid), 16'h1);
        tick();
        accept();

        // Inter-byte timeout discards a partial frame
        rand_frame();
        for (int i = 0; i < 6; i++) send_byte(cur[i], 1'b0);
        fe_at = 0;
        for (int k = 1; k <= GAP_TIMEOUT + 2; k++) begin
            err_next = (k == GAP_TIMEOUT);
            tick();
            if (frame_err && fe_at == 0) fe_at = k;
        end
        chk("timeout_latency", 16'(fe_at), 16'(GAP_TIMEOUT));
        rand_frame(); send_frame();
        chk("after_timeout_ax", accel_x, {cur[0], cur[1]});
        accept();

        // A byte on the would-be timeout edge wins
        rand_frame();
        for (int i = 0; i < 6; i++) send_byte(cur[i], 1'b0);
        repeat (GAP_TIMEOUT - 1) tick();
        for (int i = 6; i < 14; i++) send_byte(cur[i], i == 13);
        chk("byte_wins_ay",    accel_y, {cur[2], cur[3]});
        chk("byte_wins_valid", 16'(out_valid), 16'h1);
        accept();

        // rd_busy falling mid-frame discards; on the last byte it does not
        rd_busy = 1'b1; tick();
        rand_frame();
        for (int i = 0; i < 10; i++) send_byte(cur[i], 1'b0);
        rd_busy = 1'b0; err_next = 1'b1;
        tick();
        chk("rdfall_err", 16'(frame_err), 16'h1);
        tick();
        rd_busy = 1'b1; tick();
        rand_frame();
        for (int i = 0; i < 13; i++) send_byte(cur[i], 1'b0);
        rd_busy = 1'b0;
        send_byte(cur[13], 1'b1);
        chk("rdfall_last_err",   16'(frame_err), 16'h0);
        chk("rdfall_last_valid", 16'(out_valid), 16'h1);
        chk("rdfall_last_temp",  temp_raw, {cur[6], cur[7]});
        accept();

        // Two frames with no acceptance: overwrite and sticky overrun
        rand_frame(); send_frame();
        chk("ovr_first", 16'(overrun), 16'h0);
        rand_frame(); send_frame();
        chk("ovr_set",     16'(overrun),   16'h1);
        chk("ovr_valid",   16'(out_valid), 16'h1);
        chk("ovr_accel_z", accel_z, {cur[4], cur[5]});
        accept();
        chk("ovr_sticky", 16'(overrun), 16'h1);

        // Random frames, gaps and consumer back-pressure
        for (int f = 0; f < 12; f++) begin
            rand_frame();
            for (int i = 0; i < 14; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    out_ready = 1'($urandom);
                    tick();
                end
                out_ready = 1'($urandom);
                send_byte(cur[i], i == 13);
            end
        end
        out_ready = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpu_frame_assembler.md
Name: mpu_frame_assembler

Overview:
- Sits directly downstream of the MPU6050 I2C reader.
- Consumes its byte stream (one-cycle data-valid strobes) and reassembles each 14-byte burst from register 0x3B into seven signed 16-bit samples: accel X/Y/Z, temperature, gyro X/Y/Z.
- Presents each complete frame on a valid/ready output to the attitude-estimation stage.
- Detects broken or short frames via bus-idle and inter-byte timeout.

Parameters:
- FRAME_BYTES, 14, bytes per burst; fixed layout, big-endian pairs.
- GAP_TIMEOUT, 4096, clk cycles allowed between bytes inside a frame before the partial frame is discarded.
- CAL_SHIFT, 6, log2 of frames averaged for gyro bias (used only with the optional feature).

Ports:
- clk  in  1  main clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- byte_in  in  8  byte from the I2C reader
- byte_valid  in  1  one-cycle strobe; byte_in is valid in that cycle
- rd_busy  in  1  reader busy flag; high while an I2C transaction is in progress
- accel_x, accel_y, accel_z  out  16  signed, registered, last published frame
- temp_raw  out  16  signed
- gyro_x, gyro_y, gyro_z  out  16  signed
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts the frame
- frame_err  out  1  one-cycle pulse when a partial frame is discarded
- overrun  out  1  sticky; set when an unaccepted frame is overwritten; cleared only by rst
- cal_done  out  1  bias calibration complete; constant 1 when the feature is absent

Behaviour:
- Reset (rst high at a clk edge): all sample outputs 0; out_valid, frame_err, overrun 0; byte index 0; timeout counter 0; state IDLE. Reset takes priority over every other event.
- States:
  - IDLE: waiting for byte 0.
  - COLLECT: bytes 1..13 pending.
  - PUBLISH: one cycle; copy the shadow buffer to the outputs.
- IDLE -> COLLECT on byte_valid:
  - Store byte_in as byte 0 (accel_x high).
  - Byte index becomes 1.
  - Clear the timeout counter.
- COLLECT, on each byte_valid:
  - Store byte_in at the current index. Even index = high byte, odd index = low byte.
  - Order: ax, ay, az, t, gx, gy, gz.
  - Increment the index.
  - Clear the timeout counter.
  - When byte 13 is stored, go to PUBLISH.
- COLLECT without byte_valid:
  - Timeout counter increments.
  - At GAP_TIMEOUT, or on a rd_busy falling edge, discard the frame: pulse frame_err, index 0, back to IDLE.
- Simultaneous events in COLLECT:
  - byte_valid and the timeout in the same cycle: the byte wins; the counter clears.
  - byte 13 and a rd_busy falling edge in the same cycle: the frame completes normally.
- PUBLISH:
  - Outputs update and out_valid = 1 one cycle after the 14th byte_valid.
  - Return to IDLE.
  - A byte_valid arriving in the PUBLISH cycle is taken as byte 0 of the next frame.
- Handshake:
  - out_valid stays high until a cycle with out_valid && out_ready; it drops in the following cycle.
  - Outputs are stable while out_valid && !out_ready, except on overwrite.
  - Overwrite: PUBLISH while out_valid && !out_ready replaces the data, keeps out_valid high, and sets overrun.
  - Acceptance in the same cycle as PUBLISH: the new frame is published and out_valid stays 1; this is not an overrun.
- Arithmetic: samples are the concatenation {hi, lo}, interpreted as two's complement; no saturation except in the bias path.

Optional Feature:
- Macro: MPU_GYRO_BIAS_CAL_EN.
- When defined:
  - The first 2^CAL_SHIFT completed frames after reset feed per-axis signed accumulators, 16+CAL_SHIFT bits wide.
  - Those frames are not published: out_valid stays 0 and cal_done stays 0.
  - After the last of them, bias = accumulator >>> CAL_SHIFT (arithmetic shift) and cal_done rises.
  - Subsequent gyro outputs are sample minus bias, computed 17 bits wide and saturated to [-32768, 32767].
  - Accel and temperature outputs are unaffected.
  - Discarded frames do not count toward calibration.
- When undefined: no accumulators, cal_done tied to 1, gyro outputs are raw.

Decomposition:
- Shared package mpu_pkg:
  - FRAME_BYTES.
  - Byte-offset constants (AX_H = 0 … GZ_L = 13).
  - MPU_ACCEL_XOUT_H = 8'h3B.
  - Sample width 16.
  - State encoding constants.
- One natural sub-module: mpu_gyro_bias, covering the accumulate, shift, subtract and saturate path; instantiated only under the macro.

Test Plan:
- Reset with rst high for 3 cycles, then 14 strobes of bytes 0x01..0x0E -> accel_x = 0x0102, gyro_z = 0x0D0E, out_valid high exactly 1 cycle after the 14th strobe.
- Bytes 0x80,0x00 in the accel_x slot -> accel_x = -32768. Hold out_ready = 0 -> out_valid and data held constant.
- Send 6 bytes, then idle 4096 cycles -> frame_err 1-cycle pulse; next 14 bytes assemble correctly from byte 0.
- rd_busy falls after byte 9 -> frame discarded, frame_err pulses. rd_busy falls in the same cycle as byte 13 -> frame published, no error.
- Two full frames with out_ready = 0 throughout -> second frame's data is visible, overrun = 1, out_valid stays 1.
- MPU_GYRO_BIAS_CAL_EN with CAL_SHIFT = 2: 4 frames with gyro_x = 100, then a frame with gyro_x = 90 -> no out_valid during the first 4 frames, cal_done rises, published gyro_x = -10. A frame with gyro_x = -32768 and bias 100 -> output -32768 (saturated).
